// File: rtl/viterbi_frame_ctrl_if.sv
// rtl/viterbi_frame_ctrl_if.sv - received symbol-pair valid/ready bundle
interface viterbi_frame_ctrl_if;
    logic       rx_valid;
    logic [1:0] rx_pair;
    logic       rx_ready;

    modport master (output rx_valid, output rx_pair, input rx_ready);
    modport slave  (input rx_valid, input rx_pair, output rx_ready);
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// rtl/viterbi_frame_ctrl.sv - Viterbi frame sequencer; optional LOAD timeout via VITERBI_CTRL_TIMEOUT_EN
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int ADDR_W    = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    viterbi_frame_ctrl_if.slave    rx,
    output logic [1:0]             bmc_pair,
    output logic                   acs_en,
    output logic                   first_step,
    output logic                   sv_wr_en,
    output logic [ADDR_W-1:0]      sv_wr_addr,
    output logic                   tb_en,
    output logic [ADDR_W-1:0]      tb_addr,
    input  logic                   tb_bit,
    output logic                   dec_valid,
    output logic                   dec_bit,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout
);

    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_TRACE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] step_cnt;
    logic              accept;
    logic              to_hit;

    assign accept   = rx.rx_valid & rx.rx_ready;
    assign sv_wr_en = acs_en;

`ifdef VITERBI_CTRL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Count consecutive LOAD cycles without an accept; zero outside LOAD so entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state != S_LOAD || accept) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign to_hit = (state == S_LOAD) && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
`else
    // TIMEOUT only sizes the idle counter; without it LOAD waits for input indefinitely.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign to_hit         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one frame at a time, start only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (accept && step_cnt == LAST_STEP) begin
                    state_nxt = S_DRAIN;
                end else if (to_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: state_nxt = S_TRACE;
            S_TRACE: if (tb_addr == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore-style status outputs decoded from the current state.
    always_comb begin
        rx.rx_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        tb_en       = 1'b0;
        timeout     = to_hit;
        case (state)
            S_IDLE:  ;
            S_LOAD:  begin rx.rx_ready = 1'b1; busy = 1'b1; end
            S_DRAIN: busy = 1'b1;
            S_TRACE: begin tb_en = 1'b1; busy = 1'b1; end
            S_DONE:  begin done = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // Step counter: cleared on frame start, advanced once per accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            step_cnt <= '0;
        end else if (accept) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    // Register each accepted pair and fire the ACS / survivor-write strobe one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bmc_pair   <= 2'b00;
            acs_en     <= 1'b0;
            first_step <= 1'b0;
            sv_wr_addr <= '0;
        end else begin
            acs_en     <= accept;
            first_step <= accept && (step_cnt == '0);
            if (accept) begin
                bmc_pair   <= rx.rx_pair;
                sv_wr_addr <= step_cnt;
            end
        end
    end

    // Traceback address: loads the last step in DRAIN, counts down in TRACE, parks at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_addr <= '0;
        end else if (state == S_DRAIN) begin
            tb_addr <= LAST_STEP;
        end else if (state == S_TRACE && tb_addr != '0) begin
            tb_addr <= tb_addr - 1'b1;
        end
    end

    // Register the traceback unit's bit so each decoded bit trails its address by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid <= 1'b0;
            dec_bit   <= 1'b0;
        end else begin
            dec_valid <= (state == S_TRACE);
            dec_bit   <= (state == S_TRACE) ? tb_bit : 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb/tb_viterbi_frame_ctrl.sv - directed self-checking bench for viterbi_frame_ctrl
module tb_viterbi_frame_ctrl;

    localparam int FL = 8;
    localparam int AW = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    bmc_pair;
    logic          acs_en;
    logic          first_step;
    logic          sv_wr_en;
    logic [AW-1:0] sv_wr_addr;
    logic          tb_en;
    logic [AW-1:0] tb_addr;
    logic          tb_bit;
    logic          dec_valid;
    logic          dec_bit;
    logic          busy;
    logic          done;
    logic          timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acs    = 0;
    int n_done   = 0;
    int n_tb     = 0;
    int n_to     = 0;
    int n_wr_mis = 0;

    logic [1:0] pairs [FL] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10};

    viterbi_frame_ctrl_if rx_if ();

    viterbi_frame_ctrl #(.FRAME_LEN(FL), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx         (rx_if),
        .bmc_pair   (bmc_pair),
        .acs_en     (acs_en),
        .first_step (first_step),
        .sv_wr_en   (sv_wr_en),
        .sv_wr_addr (sv_wr_addr),
        .tb_en      (tb_en),
        .tb_addr    (tb_addr),
        .tb_bit     (tb_bit),
        .dec_valid  (dec_valid),
        .dec_bit    (dec_bit),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Traceback unit stand-in: decoded bit is the low address bit.
    assign tb_bit = tb_addr[0];

    always @(negedge clk) begin
        if (rst_n) begin
            n_acs  += int'(acs_en);
            n_done += int'(done);
            n_tb   += int'(tb_en);
            n_to   += int'(timeout);
            if (sv_wr_en !== acs_en) n_wr_mis++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int stall_at, input int stall_len, input bit poke);
        int cyc;
        int acs0;
        int done0;
        acs0  = n_acs;
        done0 = n_done;
        start = 1'b1;
        cyc   = 1;
        step(); cyc++;
        start = 1'b0;
        check("load_busy", busy, 1);
        for (int i = 0; i < FL; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    rx_if.rx_valid = 1'b0;
                    step(); cyc++;
                    check("stall_acs", acs_en, 0);
                    check("stall_ready", rx_if.rx_ready, 1);
                end
            end
            rx_if.rx_valid = 1'b1;
            rx_if.rx_pair  = pairs[i];
            check("load_ready", rx_if.rx_ready, 1);
            step(); cyc++;
            check("acs_en", acs_en, 1);
            check("first_step", first_step, (i == 0));
            check("bmc_pair", bmc_pair, pairs[i]);
            check("sv_wr_addr", sv_wr_addr, i);
        end
        rx_if.rx_valid = 1'b0;
        rx_if.rx_pair  = 2'b00;
        check("drain_ready", rx_if.rx_ready, 0);
        check("drain_tb_en", tb_en, 0);
        step(); cyc++;
        check("trace_tb_en", tb_en, 1);
        check("trace_acs", acs_en, 0);
        for (int k = 0; k < FL; k++) begin
            check("tb_addr", tb_addr, FL - 1 - k);
            if (poke && k == 2) start = 1'b1;
            step(); cyc++;
            start = 1'b0;
            check("dec_valid", dec_valid, 1);
            check("dec_bit", dec_bit, (FL - 1 - k) & 1);
            check("done", done, (k == FL - 1));
        end
        check("latency", cyc, 2 * FL + 3 + stall_len);
        step();
        check("idle_busy", busy, 0);
        check("idle_dec_valid", dec_valid, 0);
        check("acs_count", n_acs - acs0, FL);
        check("done_count", n_done - done0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tb0;
        int d0;
        int to0;
        int idle;
        rst_n          = 1'b0;
        start          = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_pair  = 2'b00;
        #1;
        check("reset_outs", {bmc_pair, acs_en, first_step, sv_wr_en, sv_wr_addr, tb_en, tb_addr,
                             dec_valid, dec_bit, busy, done, timeout, rx_if.rx_ready}, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("post_reset_ready", rx_if.rx_ready, 0);

        // rx_valid in IDLE is ignored
        rx_if.rx_valid = 1'b1;
        rx_if.rx_pair  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_ready", rx_if.rx_ready, 0);
            check("idle_acs", acs_en, 0);
            check("idle_busy_rx", busy, 0);
        end
        rx_if.rx_valid = 1'b0;

        run_frame(-1, 0, 1'b1);
        run_frame(3, 3, 1'b0);

        // Reset in the middle of LOAD
        d0    = n_done;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_if.rx_valid = 1'b1;
            rx_if.rx_pair  = pairs[i];
            step();
        end
        check("pre_rst_addr", sv_wr_addr, 2);
        rst_n          = 1'b0;
        rx_if.rx_valid = 1'b0;
        #1;
        check("mid_rst_outs", {bmc_pair, acs_en, first_step, sv_wr_en, sv_wr_addr, tb_en, tb_addr,
                               dec_valid, dec_bit, busy, done, timeout, rx_if.rx_ready}, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_ready", rx_if.rx_ready, 0);
        check("rst_busy", busy, 0);
        step();
        check("rst_no_done", n_done - d0, 0);

`ifdef VITERBI_CTRL_TIMEOUT_EN
        tb0   = n_tb;
        d0    = n_done;
        to0   = n_to;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_if.rx_valid = 1'b1;
            rx_if.rx_pair  = pairs[i];
            step();
        end
        rx_if.rx_valid = 1'b0;
        check("to_last_acs", acs_en, 1);
        idle = 1;
        while (timeout !== 1'b1 && idle < 40) begin
            step();
            idle++;
        end
        check("to_cycle", idle, TO);
        step();
        check("to_busy", busy, 0);
        check("to_pulse_len", timeout, 0);
        step(); step();
        check("to_tb_never", n_tb - tb0, 0);
        check("to_no_done", n_done - d0, 0);
        check("to_pulse_count", n_to - to0, 1);
`else
        tb0 = 0; d0 = 0; to0 = 0; idle = 0;
        check("timeout_never", n_to, 0);
`endif
        check("wr_en_eq_acs", n_wr_mis, 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
